// File: rtl/abr_masked_add_arb_pkg.sv
// Shared types for the masked two-share adder arbiter.
// Share pairs are [share][bit]; the two shares are never combined.
`ifndef ABR_MASKED_ADD_ARB_PKG_SV
`define ABR_MASKED_ADD_ARB_PKG_SV

package abr_masked_add_arb_pkg;

    localparam int NUM_SHARES = 2;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        PEND = 2'd1,
        FULL = 2'd2
    } slot_state_e;

endpackage

`define ABR_SHARE_PAIR_T(W) logic [abr_masked_add_arb_pkg::NUM_SHARES-1:0][(W)-1:0]

`endif

// File: rtl/abr_masked_N_bit_Arith_adder.sv
// Share-wise modular-2^WIDTH adder with one output register stage.
// Carries never cross from one share into the other.
module abr_masked_N_bit_Arith_adder
    import abr_masked_add_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   zeroize,
    input  `ABR_SHARE_PAIR_T(WIDTH) x_i,
    input  `ABR_SHARE_PAIR_T(WIDTH) y_i,
    output `ABR_SHARE_PAIR_T(WIDTH) s_o
);

    `ABR_SHARE_PAIR_T(WIDTH) s_d;
    `ABR_SHARE_PAIR_T(WIDTH) s_q;

    always_comb begin
        s_d = '0;
        for (int sh = 0; sh < NUM_SHARES; sh++) begin
            s_d[sh] = x_i[sh] + y_i[sh];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
        end else if (zeroize) begin
            s_q <= '0;
        end else begin
            s_q <= s_d;
        end
    end

    assign s_o = s_q;

endmodule

// File: rtl/abr_masked_add_arbiter.sv
// Round-robin sharing of one masked adder with a one-deep result slot per requester.
// Optional ABR_MASKED_ADD_ARB_IDLE_CLEAR_EN zeroes adder inputs in idle cycles.
module abr_masked_add_arbiter
    import abr_masked_add_arb_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        zeroize,
    input  logic [NUM_REQ-1:0]                          req_valid_i,
    output logic [NUM_REQ-1:0]                          req_ready_o,
    input  logic [NUM_REQ-1:0][NUM_SHARES-1:0][WIDTH-1:0] req_x_i,
    input  logic [NUM_REQ-1:0][NUM_SHARES-1:0][WIDTH-1:0] req_y_i,
    output logic [NUM_REQ-1:0]                          rsp_valid_o,
    input  logic [NUM_REQ-1:0]                          rsp_ready_i,
    output logic [NUM_REQ-1:0][NUM_SHARES-1:0][WIDTH-1:0] rsp_s_o,
    output logic                                        busy_o
);

    typedef `ABR_SHARE_PAIR_T(WIDTH) pair_t;

    slot_state_e        slot_q [NUM_REQ];
    slot_state_e        slot_d [NUM_REQ];
    pair_t              data_q [NUM_REQ];
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    pipe_id_q;
    logic               pipe_valid_q;
    logic [NUM_REQ-1:0] elig;
    logic               gnt;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    idx;
    pair_t              add_x;
    pair_t              add_y;
    pair_t              add_s;

    always_comb begin
        elig = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            elig[r] = req_valid_i[r] &&
                      (slot_q[r] == FREE ||
                       (slot_q[r] == FULL && rsp_ready_i[r]));
        end
    end

    // Search starts just above the last winner; idle leaves gnt_id at rr_ptr.
    always_comb begin
        gnt    = 1'b0;
        gnt_id = rr_ptr_q;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!gnt && elig[idx] && rst_n && !zeroize) begin
                gnt    = 1'b1;
                gnt_id = idx;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_ready_o[r] = gnt && (gnt_id == ID_W'(r));
        end
    end

    always_comb begin
`ifdef ABR_MASKED_ADD_ARB_IDLE_CLEAR_EN
        add_x = gnt ? req_x_i[gnt_id] : '0;
        add_y = gnt ? req_y_i[gnt_id] : '0;
`else
        add_x = req_x_i[gnt_id];
        add_y = req_y_i[gnt_id];
`endif
    end

    abr_masked_N_bit_Arith_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .clk     (clk),
        .rst_n   (rst_n),
        .zeroize (zeroize),
        .x_i     (add_x),
        .y_i     (add_y),
        .s_o     (add_s)
    );

    always_comb begin
        for (int r = 0; r < NUM_REQ; r++) begin
            slot_d[r] = slot_q[r];
            unique case (slot_q[r])
                FREE: if (req_ready_o[r]) slot_d[r] = PEND;
                PEND: if (pipe_valid_q && pipe_id_q == ID_W'(r)) slot_d[r] = FULL;
                FULL: begin
                    if (req_ready_o[r])      slot_d[r] = PEND;
                    else if (rsp_ready_i[r]) slot_d[r] = FREE;
                end
                default: slot_d[r] = FREE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            pipe_valid_q <= 1'b0;
            pipe_id_q    <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                slot_q[r] <= FREE;
                data_q[r] <= '0;
            end
        end else if (zeroize) begin
            rr_ptr_q     <= '0;
            pipe_valid_q <= 1'b0;
            pipe_id_q    <= '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                slot_q[r] <= FREE;
                data_q[r] <= '0;
            end
        end else begin
            if (gnt) rr_ptr_q <= gnt_id;
            pipe_valid_q <= gnt;
            pipe_id_q    <= gnt_id;
            for (int r = 0; r < NUM_REQ; r++) begin
                slot_q[r] <= slot_d[r];
                if (pipe_valid_q && pipe_id_q == ID_W'(r)) data_q[r] <= add_s;
            end
        end
    end

    always_comb begin
        busy_o      = pipe_valid_q;
        rsp_valid_o = '0;
        rsp_s_o     = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            rsp_valid_o[r] = (slot_q[r] == FULL);
            rsp_s_o[r]     = data_q[r];
            if (slot_q[r] != FREE) busy_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_abr_masked_add_arbiter.sv
// Directed-vector bench for abr_masked_add_arbiter (WIDTH=8, NUM_REQ=2).
// Expected values are hand-computed constants.
module tb_abr_masked_add_arbiter;

    localparam int W = 8;
    localparam int N = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     zeroize;
    logic [N-1:0]             req_valid_i;
    logic [N-1:0]             req_ready_o;
    logic [N-1:0][1:0][W-1:0] req_x_i;
    logic [N-1:0][1:0][W-1:0] req_y_i;
    logic [N-1:0]             rsp_valid_o;
    logic [N-1:0]             rsp_ready_i;
    logic [N-1:0][1:0][W-1:0] rsp_s_o;
    logic                     busy_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    abr_masked_add_arbiter #(
        .WIDTH   (W),
        .NUM_REQ (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .zeroize     (zeroize),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_x_i     (req_x_i),
        .req_y_i     (req_y_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_s_o     (rsp_s_o),
        .busy_o      (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] eg;

    initial begin
        rst_n       = 1'b0;
        zeroize     = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = '0;
        req_x_i     = '0;
        req_y_i     = '0;
        #2;
        req_valid_i = 2'b11;
        #1;
        chk("rst_ready", req_ready_o, 2'b00);
        chk("rst_rspv", rsp_valid_o, 2'b00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_data", rsp_s_o, 32'h0);
        req_valid_i = '0;
        step();
        step();
        rst_n = 1'b1;

        // single op on r0
        step();
        req_x_i[0]  = {8'h34, 8'h12};
        req_y_i[0]  = {8'h02, 8'h01};
        req_valid_i = 2'b01;
        #1;
        chk("t1_ready", req_ready_o, 2'b01);
        step();
        req_valid_i = '0;
        #1;
        chk("t1_lat1", rsp_valid_o, 2'b00);
        chk("t1_busy", busy_o, 1'b1);
        step();
        #1;
        chk("t1_valid", rsp_valid_o, 2'b01);
        chk("t1_data", rsp_s_o[0], 16'h3613);
        rsp_ready_i = 2'b01;
        step();
        rsp_ready_i = '0;
        #1;
        chk("t1_idle", busy_o, 1'b0);
        chk("t1_gone", rsp_valid_o, 2'b00);

        // share wrap on r1
        step();
        req_x_i[1]  = {8'h80, 8'hFF};
        req_y_i[1]  = {8'h80, 8'h02};
        req_valid_i = 2'b10;
        #1;
        chk("t2_ready", req_ready_o, 2'b10);
        step();
        req_valid_i = '0;
        step();
        #1;
        chk("t2_valid", rsp_valid_o, 2'b10);
        chk("t2_data", rsp_s_o[1], 16'h0001);
        rsp_ready_i = 2'b10;
        step();
        rsp_ready_i = '0;

        // contention from a fresh reset
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req_x_i[0]  = {8'h20, 8'h10};
        req_y_i[0]  = {8'h01, 8'h01};
        req_x_i[1]  = {8'h40, 8'h30};
        req_y_i[1]  = {8'h06, 8'h05};
        req_valid_i = 2'b11;
        rsp_ready_i = 2'b11;
        for (int c = 0; c < 100; c++) begin
            eg = (c % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            chk("cont_gnt", req_ready_o, eg);
            chk("cont_rspv", rsp_valid_o, (c >= 2) ? eg : 2'b00);
            if (c >= 2)
                chk("cont_data", eg[0] ? rsp_s_o[0] : rsp_s_o[1],
                    eg[0] ? 16'h2111 : 16'h4635);
            step();
        end
        req_valid_i = '0;
        step();
        step();
        step();
        #1;
        chk("drain_idle", busy_o, 1'b0);

        // back-pressure on r0
        step();
        rsp_ready_i = 2'b10;
        req_valid_i = 2'b11;
        for (int b = 0; b < 8; b++) begin
            case (b)
                0, 2, 4, 6: eg = 2'b10;
                1:          eg = 2'b01;
                default:    eg = 2'b00;
            endcase
            #1;
            chk("bp_gnt", req_ready_o, eg);
            if (b >= 3) begin
                chk("bp_hold", rsp_valid_o[0], 1'b1);
                chk("bp_data", rsp_s_o[0], 16'h2111);
            end
            step();
        end
        rsp_ready_i = 2'b11;
        #1;
        chk("bp_release", req_ready_o, 2'b01);
        step();
        #1;
        chk("bp_next", req_ready_o, 2'b10);
        chk("bp_rspv", rsp_valid_o, 2'b00);
        req_valid_i = '0;
        step();
        step();
        step();
        step();
        #1;
        chk("bp_idle", busy_o, 1'b0);

        // zeroize with r0 PEND and r1 FULL
        rsp_ready_i = '0;
        step();
        req_valid_i = 2'b10;
        #1;
        chk("z_g1", req_ready_o, 2'b10);
        step();
        req_valid_i = 2'b01;
        #1;
        chk("z_g0", req_ready_o, 2'b01);
        step();
        req_valid_i = 2'b10;
        rsp_ready_i = 2'b10;
        zeroize     = 1'b1;
        #1;
        chk("z_pre_v", rsp_valid_o, 2'b10);
        chk("z_pre_d", rsp_s_o[1], 16'h4635);
        chk("z_block", req_ready_o, 2'b00);
        step();
        zeroize     = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = '0;
        #1;
        chk("z_rspv", rsp_valid_o, 2'b00);
        chk("z_data", rsp_s_o, 32'h0);
        chk("z_busy", busy_o, 1'b0);
        step();
        #1;
        chk("z_nowr", rsp_valid_o, 2'b00);
        chk("z_busy2", busy_o, 1'b0);

        // async reset mid-stream
        req_valid_i = 2'b11;
        rsp_ready_i = 2'b11;
        #1;
        chk("ar_g0", req_ready_o, 2'b10);
        step();
        #1;
        chk("ar_g1", req_ready_o, 2'b01);
        step();
        #1;
        chk("ar_g2", req_ready_o, 2'b10);
        step();
        #1;
        chk("ar_busy", busy_o, 1'b1);
        chk("ar_g3", req_ready_o, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("ar_rspv", rsp_valid_o, 2'b00);
        chk("ar_busy0", busy_o, 1'b0);
        chk("ar_ready", req_ready_o, 2'b00);
        chk("ar_data", rsp_s_o, 32'h0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("ar_first", req_ready_o, 2'b10);
        req_valid_i = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
